// File: rtl/weight_replay_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_replay_pkg                                                        |
// | Shared state type and counter-width helper for the weight replay buffer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package weight_replay_pkg;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } replay_state_t;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_replay_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_replay_mem                                                        |
// | DEPTH x WIDTH flop array, one write port, one combinational read port.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module weight_replay_mem
    import weight_replay_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16,
    parameter int ADDR_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    // Contents are not reset: a fresh capture always overwrites every entry
    // before any of them is read back.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/weight_replay_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | weight_replay_buffer                                                     |
// | Captures one DEPTH-beat weight tensor, then replays it REPEAT times.     |
// | Option: WEIGHT_REPLAY_PASSTHRU_EN forwards pass 0 while capturing.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module weight_replay_buffer
    import weight_replay_pkg::*;
#(
    parameter int WEIGHT_PRECISION_0       = 16,
    parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
    parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
    parameter int DEPTH                    = 32,
    parameter int REPEAT                   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0][WEIGHT_PRECISION_0-1:0] data_in,
    input  logic data_in_valid,
    output logic data_in_ready,
    output logic [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0][WEIGHT_PRECISION_0-1:0] data_out,
    output logic data_out_valid,
    input  logic data_out_ready,
    output logic [cnt_width(REPEAT+1)-1:0] pass_idx
);

    localparam int c_BEAT_W = WEIGHT_PRECISION_0 * WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
    localparam int c_PTR_W  = cnt_width(DEPTH);
    localparam int c_PASS_W = cnt_width(REPEAT + 1);

    replay_state_t        r_state;
    replay_state_t        w_next_state;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PASS_W-1:0]  r_pass_idx;
    logic [c_BEAT_W-1:0]  w_rd_data;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic [c_BEAT_W-1:0]  w_out_data;
    logic                 w_wr_en;
    logic                 w_rd_fire;
    logic                 w_wr_last;
    logic                 w_rd_last;
    logic                 w_pass_last;
    logic                 w_fill_done;

    assign w_wr_last   = (r_wr_ptr == c_PTR_W'(DEPTH - 1));
    assign w_rd_last   = (r_rd_ptr == c_PTR_W'(DEPTH - 1));
    assign w_pass_last = (r_pass_idx == c_PASS_W'(REPEAT - 1));

    weight_replay_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (c_BEAT_W),
        .ADDR_W (c_PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_out_data   = w_rd_data;
        w_wr_en      = 1'b0;
        w_rd_fire    = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            FILL: begin
`ifdef WEIGHT_REPLAY_PASSTHRU_EN
                w_in_ready  = data_out_ready;
                w_out_valid = data_in_valid;
                w_out_data  = data_in;
`else
                w_in_ready  = 1'b1;
`endif
                w_wr_en     = data_in_valid && w_in_ready;
                w_fill_done = w_wr_en && w_wr_last;
`ifdef WEIGHT_REPLAY_PASSTHRU_EN
                // Pass 0 already went out during capture; a single-pass
                // configuration therefore has nothing left to replay.
                if (w_fill_done && (REPEAT > 1)) begin
                    w_next_state = REPLAY;
                end
`else
                if (w_fill_done) begin
                    w_next_state = REPLAY;
                end
`endif
            end
            REPLAY: begin
                w_out_valid = 1'b1;
                w_rd_fire   = data_out_ready;
                if (w_rd_fire && w_rd_last && w_pass_last) begin
                    w_next_state = FILL;
                end
            end
            default: begin
                w_next_state = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pass_idx <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
`ifdef WEIGHT_REPLAY_PASSTHRU_EN
            if (w_fill_done && (REPEAT > 1)) begin
                r_pass_idx <= c_PASS_W'(1);
            end
`endif
            if (w_rd_fire) begin
                r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + c_PTR_W'(1);
                if (w_rd_last) begin
                    r_pass_idx <= w_pass_last ? '0 : r_pass_idx + c_PASS_W'(1);
                end
            end
        end
    end

    assign data_in_ready  = w_in_ready;
    assign data_out_valid = w_out_valid;
    assign data_out       = w_out_data;
    assign pass_idx       = r_pass_idx;

endmodule
`default_nettype wire

// File: tb/tb_weight_replay_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_weight_replay_buffer                                                  |
// | Randomised stream bench with a capture/replay counting model.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_weight_replay_buffer;

    localparam int DEPTH  = 32;
    localparam int REPEAT = 4;
`ifdef WEIGHT_REPLAY_PASSTHRU_EN
    localparam bit PT = 1'b1;
`else
    localparam bit PT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [0:0][15:0] din  = '0;
    logic            din_valid = 1'b0;
    logic            din_ready;
    logic [0:0][15:0] dout;
    logic            dout_valid;
    logic            dout_ready = 1'b0;
    logic [2:0]      pass_idx;

    logic [0:0][15:0] s_din = '0;
    logic            s_vld = 1'b0;
    logic            s_rdy;
    logic [0:0][15:0] s_dout;
    logic            s_ovld;
    logic            s_ordy = 1'b0;
    logic [0:0]      s_pass;

    weight_replay_buffer #(
        .WEIGHT_PRECISION_0(16), .WEIGHT_PARALLELISM_DIM_0(1), .WEIGHT_PARALLELISM_DIM_1(1),
        .DEPTH(DEPTH), .REPEAT(REPEAT)
    ) u_dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready),
        .data_out(dout), .data_out_valid(dout_valid), .data_out_ready(dout_ready),
        .pass_idx(pass_idx)
    );

    weight_replay_buffer #(
        .WEIGHT_PRECISION_0(16), .WEIGHT_PARALLELISM_DIM_0(1), .WEIGHT_PARALLELISM_DIM_1(1),
        .DEPTH(1), .REPEAT(1)
    ) u_small (
        .clk(clk), .rst(rst),
        .data_in(s_din), .data_in_valid(s_vld), .data_in_ready(s_rdy),
        .data_out(s_dout), .data_out_valid(s_ovld), .data_out_ready(s_ordy),
        .pass_idx(s_pass)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a capture collects DEPTH accepted beats; afterwards the output
    // stream is those beats in order, repeated, until DEPTH*REPEAT have left.
    int          n_in = 0;
    int          n_out = 0;
    int          done_cnt = 0;
    logic [15:0] cap [DEPTH];
    logic [15:0] log_q [$];
    int          pass_q [$];

    always @(negedge clk) begin : p_check
        bit          e_rdy;
        bit          e_vld;
        logic [15:0] e_dat;
        if (rst) begin
            n_in  = 0;
            n_out = 0;
        end else begin
            if (n_in < DEPTH) begin
                e_rdy = PT ? dout_ready : 1'b1;
                e_vld = PT ? din_valid : 1'b0;
                e_dat = din;
            end else begin
                e_rdy = 1'b0;
                e_vld = 1'b1;
                e_dat = cap[n_out % DEPTH];
            end
            chk("data_in_ready", 32'(din_ready), 32'(e_rdy));
            chk("data_out_valid", 32'(dout_valid), 32'(e_vld));
            chk("pass_idx", 32'(pass_idx), 32'(n_out / DEPTH));
            if (e_vld) chk("data_out", 32'(dout), 32'(e_dat));
            if (din_valid && e_rdy) begin
                cap[n_in] = din;
                n_in++;
            end
            if (e_vld && dout_ready) begin
                log_q.push_back(dout);
                pass_q.push_back(int'(pass_idx));
                n_out++;
            end
            if (n_in == DEPTH && n_out == DEPTH * REPEAT) begin
                n_in  = 0;
                n_out = 0;
                done_cnt++;
            end
        end
    end

    int first_low;

    // Streams nbeats input beats; vmode 1 offers a beat 1 cycle in 3, rmode 1
    // randomises data_out_ready. Ends on set completion or when stop_out
    // output beats have been logged (stop_out > 0).
    task automatic run(input int nbeats, input int vmode, input int rmode, input bit rand_data,
                       input int stop_out, input int max_cyc);
        int          k = 0;
        int          cyc = 0;
        int          start = done_cnt;
        int          base = log_q.size();
        bit          fire = 1'b0;
        bit          fin = 1'b0;
        logic [15:0] cur;
        cur = rand_data ? 16'($urandom) : 16'(0);
        first_low = -1;
        while (!fin && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            if (fire) begin
                k++;
                cur = rand_data ? 16'($urandom) : 16'(k);
            end
            if (!(din_valid && !fire))
                din_valid = (k < nbeats) && (vmode == 0 || $urandom_range(0, 2) == 0);
            if (k >= nbeats) din_valid = 1'b0;
            din = cur;
            dout_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            fire = din_valid && din_ready;
            if (!din_ready && first_low < 0) first_low = cyc;
            cyc++;
            fin = (stop_out > 0) ? (log_q.size() - base >= stop_out) : (done_cnt != start);
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: got %0d cycles required completion", cyc);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        dout_ready = 1'b0;
    endtask

    initial begin
        int b;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(din_ready), 32'd1);
        chk("reset_out_valid", 32'(dout_valid), 32'd0);
        chk("reset_pass_idx", 32'(pass_idx), 32'd0);

        // Test 1: straight capture of 0..31, full-rate replay.
        b = log_q.size();
        run(DEPTH, 0, 0, 1'b0, 0, 1000);
        chk("t1_ready_low_cycle", 32'(first_low), 32'd32);
        chk("t1_beats", 32'(log_q.size() - b), 32'd128);
        chk("t1_beat0", 32'(log_q[b]), 32'd0);
        chk("t1_beat31", 32'(log_q[b + 31]), 32'd31);
        chk("t1_beat32", 32'(log_q[b + 32]), 32'd0);
        chk("t1_beat127", 32'(log_q[b + 127]), 32'd31);
        chk("t1_pass_b0", 32'(pass_q[b]), 32'd0);
        chk("t1_pass_b40", 32'(pass_q[b + 40]), 32'd1);
        chk("t1_pass_b127", 32'(pass_q[b + 127]), 32'd3);
        @(negedge clk);
        chk("t1_back_to_fill", 32'(din_ready), 32'd1);

        // Test 2: random downstream stalls.
        b = log_q.size();
        run(DEPTH, 0, 1, 1'b0, 0, 2000);
        chk("t2_beats", 32'(log_q.size() - b), 32'd128);
        chk("t2_beat97", 32'(log_q[b + 97]), 32'd1);

        // Test 3: sparse upstream valid, random data.
        run(DEPTH, 1, 0, 1'b1, 0, 2000);
        run(DEPTH, 1, 1, 1'b1, 0, 3000);

        // Test 4: asynchronous reset after 10 beats of pass 2.
        run(DEPTH, 0, 0, 1'b0, 2 * DEPTH + 10, 1000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_out_valid", 32'(dout_valid), 32'd0);
        chk("t4_async_pass_idx", 32'(pass_idx), 32'd0);
        chk("t4_async_in_ready", 32'(din_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(DEPTH, 0, 1, 1'b1, 0, 2000);

        // Test 5: DEPTH=1, REPEAT=1 instance.
        @(posedge clk);
        #1;
        s_vld = 1'b1;
        s_din = 16'hA5A5;
        s_ordy = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", 32'(s_rdy), 32'd1);
`ifdef WEIGHT_REPLAY_PASSTHRU_EN
        chk("t5_fwd_valid", 32'(s_ovld), 32'd1);
        chk("t5_fwd_data", 32'(s_dout), 32'hA5A5);
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        @(negedge clk);
        chk("t5_no_replay", 32'(s_ovld), 32'd0);
        chk("t5_still_fill", 32'(s_rdy), 32'd1);
`else
        chk("t5_silent_fill", 32'(s_ovld), 32'd0);
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        @(negedge clk);
        chk("t5_replay_valid", 32'(s_ovld), 32'd1);
        chk("t5_replay_data", 32'(s_dout), 32'hA5A5);
        chk("t5_replay_blocked", 32'(s_rdy), 32'd0);
        chk("t5_pass", 32'(s_pass), 32'd0);
        @(negedge clk);
        chk("t5_back_valid", 32'(s_ovld), 32'd0);
        chk("t5_back_ready", 32'(s_rdy), 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
